// File: rtl/tx_fifo_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo_arb_if
// Description : Request/ack and FIFO write-side signals of the tx_fifo_arb.
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_fifo_arb_if #(
    parameter int DATA_WD = 8
);
    logic                   rd_req;
    logic [DATA_WD-1:0]     rd_data;
    logic                   rd_ack;
    logic                   alu_req;
    logic [2*DATA_WD-1:0]   alu_data;
    logic                   alu_ack;
    logic                   fifo_full;
    logic [DATA_WD-1:0]     fifo_wr_data;
    logic                   wr_inc;
    logic                   busy;

    // Arbiter side.
    modport slave (
        input  rd_req,
        input  rd_data,
        output rd_ack,
        input  alu_req,
        input  alu_data,
        output alu_ack,
        input  fifo_full,
        output fifo_wr_data,
        output wr_inc,
        output busy
    );

    // Requester / FIFO side.
    modport master (
        output rd_req,
        output rd_data,
        input  rd_ack,
        output alu_req,
        output alu_data,
        input  alu_ack,
        output fifo_full,
        input  fifo_wr_data,
        input  wr_inc,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/tx_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo_arb
// Description : Round-robin arbiter serialising register-read bytes and
//               two-byte ALU words into an async-FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo_arb #(
    parameter int DATA_WD = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    tx_fifo_arb_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SEND_RD     = 2'd1,
        ST_SEND_ALU_LO = 2'd2,
        ST_SEND_ALU_HI = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_prio;
    logic [2*DATA_WD-1:0]   r_hold;

    logic                   w_rd_ack;
    logic                   w_alu_ack;
    logic                   w_wr_inc;
    logic [DATA_WD-1:0]     w_wr_data;

    // Grants only from IDLE; a stalled SEND state holds everything in place.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_ack    = 1'b0;
        w_alu_ack   = 1'b0;
        w_wr_inc    = 1'b0;
        w_wr_data   = r_hold[DATA_WD-1:0];
        case (r_state)
            ST_IDLE: begin
                if (bus.rd_req && (!bus.alu_req || !r_prio)) begin
                    w_rd_ack    = 1'b1;
                    w_state_nxt = ST_SEND_RD;
                end else if (bus.alu_req) begin
                    w_alu_ack   = 1'b1;
                    w_state_nxt = ST_SEND_ALU_LO;
                end
            end
            ST_SEND_RD: begin
                w_wr_inc = !bus.fifo_full;
                if (!bus.fifo_full) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND_ALU_LO: begin
                w_wr_inc = !bus.fifo_full;
                if (!bus.fifo_full) begin
                    w_state_nxt = ST_SEND_ALU_HI;
                end
            end
            ST_SEND_ALU_HI: begin
                w_wr_inc  = !bus.fifo_full;
                w_wr_data = r_hold[2*DATA_WD-1:DATA_WD];
                if (!bus.fifo_full) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_ack) begin
                r_hold <= {{DATA_WD{1'b0}}, bus.rd_data};
                r_prio <= 1'b1;
            end else if (w_alu_ack) begin
                r_hold <= bus.alu_data;
                r_prio <= 1'b0;
            end
        end
    end

    assign bus.rd_ack       = w_rd_ack;
    assign bus.alu_ack      = w_alu_ack;
    assign bus.wr_inc       = w_wr_inc;
    assign bus.fifo_wr_data = w_wr_data;
    assign bus.busy         = (r_state != ST_IDLE);

    a_one_ack: assert property (@(posedge clk) disable iff (rst)
        !(w_rd_ack && w_alu_ack));
    a_ack_idle: assert property (@(posedge clk) disable iff (rst)
        (w_rd_ack || w_alu_ack) |-> (r_state == ST_IDLE));
    a_write_busy: assert property (@(posedge clk) disable iff (rst)
        w_wr_inc |-> (r_state != ST_IDLE));
endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_fifo_arb
// Description : Directed and random stimulus checked against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_fifo_arb;
    localparam int DATA_WD = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tx_fifo_arb_if #(.DATA_WD(DATA_WD)) bus ();

    tx_fifo_arb #(.DATA_WD(DATA_WD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Requester drive state
    logic                  d_rd_req   = 1'b0;
    logic [DATA_WD-1:0]    d_rd_data  = '0;
    logic                  d_alu_req  = 1'b0;
    logic [2*DATA_WD-1:0]  d_alu_data = '0;
    logic                  d_full     = 1'b0;
    bit                    hold_rd    = 1'b0;
    bit                    hold_alu   = 1'b0;
    bit                    hs_rd      = 1'b0;
    bit                    hs_alu     = 1'b0;

    // Reference model: bytes owed to the FIFO, arbitration pointer, last low byte
    logic [DATA_WD-1:0]    pend[$];
    bit                    m_prio    = 1'b0;
    logic [DATA_WD-1:0]    m_last_lo = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=0x%0h exp=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_prio    = 1'b0;
        m_last_lo = '0;
    endtask

    // One clock: apply inputs at negedge, check outputs, advance the model
    task automatic step();
        bit                 e_rd_ack;
        bit                 e_alu_ack;
        bit                 e_wr;
        logic [DATA_WD-1:0] e_data;
        @(negedge clk);
        bus.rd_req    = d_rd_req;
        bus.rd_data   = d_rd_data;
        bus.alu_req   = d_alu_req;
        bus.alu_data  = d_alu_data;
        bus.fifo_full = d_full;
        #1;
        e_rd_ack  = 1'b0;
        e_alu_ack = 1'b0;
        if (pend.size() == 0) begin
            if (d_rd_req && (!d_alu_req || !m_prio))
                e_rd_ack = 1'b1;
            else if (d_alu_req)
                e_alu_ack = 1'b1;
        end
        e_wr   = (pend.size() != 0) && !d_full;
        e_data = (pend.size() != 0) ? pend[0] : m_last_lo;
        chk("rd_ack",  {31'd0, bus.rd_ack},  {31'd0, e_rd_ack});
        chk("alu_ack", {31'd0, bus.alu_ack}, {31'd0, e_alu_ack});
        chk("wr_inc",  {31'd0, bus.wr_inc},  {31'd0, e_wr});
        chk("busy",    {31'd0, bus.busy},    {31'd0, (pend.size() != 0)});
        chk("wr_data", {24'd0, bus.fifo_wr_data}, {24'd0, e_data});
        hs_rd  = e_rd_ack;
        hs_alu = e_alu_ack;
        if (e_wr)
            void'(pend.pop_front());
        if (hs_rd) begin
            pend.push_back(d_rd_data);
            m_last_lo = d_rd_data;
            m_prio    = 1'b1;
        end else if (hs_alu) begin
            pend.push_back(d_alu_data[DATA_WD-1:0]);
            pend.push_back(d_alu_data[2*DATA_WD-1:DATA_WD]);
            m_last_lo = d_alu_data[DATA_WD-1:0];
            m_prio    = 1'b0;
        end
    endtask

    task automatic drive_update(input bit rnd);
        if (hs_rd) begin
            d_rd_req  = hold_rd;
            d_rd_data = DATA_WD'($urandom);
        end
        if (hs_alu) begin
            d_alu_req  = hold_alu;
            d_alu_data = (2*DATA_WD)'($urandom);
        end
        if (rnd) begin
            if (!d_rd_req && $urandom_range(0, 2) == 0) begin
                d_rd_req  = 1'b1;
                d_rd_data = DATA_WD'($urandom);
            end
            if (!d_alu_req && $urandom_range(0, 2) == 0) begin
                d_alu_req  = 1'b1;
                d_alu_data = (2*DATA_WD)'($urandom);
            end
            d_full = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            step();
            drive_update(rnd);
        end
    endtask

    initial begin
        bus.rd_req    = 1'b0;
        bus.rd_data   = '0;
        bus.alu_req   = 1'b0;
        bus.alu_data  = '0;
        bus.fifo_full = 1'b0;

        // Power-on reset
        #2 rst = 1'b1;
        #1;
        chk("rst_wr_inc",  {31'd0, bus.wr_inc},       32'd0);
        chk("rst_busy",    {31'd0, bus.busy},         32'd0);
        chk("rst_wr_data", {24'd0, bus.fifo_wr_data}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Single RD byte
        d_rd_req  = 1'b1;
        d_rd_data = 8'hA5;
        run(3, 1'b0);

        // Single ALU word
        d_alu_req  = 1'b1;
        d_alu_data = 16'h1234;
        run(4, 1'b0);

        // Both requesters held continuously: round-robin alternation
        hold_rd    = 1'b1;
        hold_alu   = 1'b1;
        d_rd_req   = 1'b1;
        d_rd_data  = 8'h11;
        d_alu_req  = 1'b1;
        d_alu_data = 16'h2233;
        run(15, 1'b0);
        hold_rd  = 1'b0;
        hold_alu = 1'b0;
        run(8, 1'b0);

        // FIFO full for 5 cycles while the high byte is pending
        d_rd_req   = 1'b0;
        d_alu_req  = 1'b1;
        d_alu_data = 16'h1234;
        run(2, 1'b0);
        d_full = 1'b1;
        run(5, 1'b0);
        d_full = 1'b0;
        run(2, 1'b0);

        // Reset while in the low-byte send state
        d_alu_req  = 1'b1;
        d_alu_data = 16'hBEEF;
        run(1, 1'b0);
        chk("mid_rst_granted", {31'd0, hs_alu}, 32'd1);
        @(negedge clk);
        #1;
        bus.rd_req  = 1'b0;
        bus.alu_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_inc",  {31'd0, bus.wr_inc},       32'd0);
        chk("mid_rst_busy",    {31'd0, bus.busy},         32'd0);
        chk("mid_rst_wr_data", {24'd0, bus.fifo_wr_data}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Priority back at RD after reset
        d_rd_req   = 1'b1;
        d_rd_data  = 8'h5A;
        d_alu_req  = 1'b1;
        d_alu_data = 16'hBEEF;
        run(8, 1'b0);

        // Random traffic with random back-pressure
        run(3000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/tx_fifo_arb.md
TX_FIFO_ARB -- requirements
Module: tx_fifo_arb

Interface
REQ-001 Parameter: DATA_WD, default 8, byte width of the FIFO write port and of the register-read response.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 RD_REQ  input  1  register-read response valid; held high with RD_DATA stable until transfer.
REQ-005 RD_DATA  input  DATA_WD  register-read response byte.
REQ-006 RD_ACK  output  1  ready for the read requester; transfer occurs on an edge where RD_REQ && RD_ACK.
REQ-007 ALU_REQ  input  1  ALU result valid; held high with ALU_DATA stable until transfer.
REQ-008 ALU_DATA  input  2*DATA_WD  ALU result word.
REQ-009 ALU_ACK  output  1  ready for the ALU requester; transfer on an edge where ALU_REQ && ALU_ACK.
REQ-010 FIFO_FULL  input  1  async-FIFO write-side full flag.
REQ-011 FIFO_WR_DATA  output  DATA_WD  byte presented to the FIFO write port.
REQ-012 WR_INC  output  1  FIFO write strobe, one byte per high cycle.
REQ-013 BUSY  output  1  high whenever a captured transfer is not yet fully written.

Function
REQ-014 States: IDLE, SEND_RD, SEND_ALU_LO, SEND_ALU_HI, held in a state register.
REQ-015 RD_ACK and ALU_ACK are combinational and high only in IDLE; at most one is high in any cycle.
REQ-016 IDLE, one request high: that requester's ACK is high.
REQ-017 IDLE, both requests high: ACK goes to the requester holding priority bit PRIO (0 = RD, 1 = ALU).
REQ-018 After every completed transfer handshake, PRIO points to the requester not just served (round-robin).
REQ-019 On the RD transfer edge: RD_DATA is captured into the low byte of a 2*DATA_WD hold register; next state is SEND_RD.
REQ-020 On the ALU transfer edge: ALU_DATA is captured into the hold register; next state is SEND_ALU_LO.
REQ-021 WR_INC = (state in SEND_RD, SEND_ALU_LO or SEND_ALU_HI) && !FIFO_FULL, combinational.
REQ-022 FIFO_WR_DATA is hold[DATA_WD-1:0] in SEND_RD and SEND_ALU_LO, hold[2*DATA_WD-1:DATA_WD] in SEND_ALU_HI, and hold low byte otherwise.
REQ-023 Transitions on write cycles: SEND_RD -> IDLE; SEND_ALU_LO -> SEND_ALU_HI; SEND_ALU_HI -> IDLE.
REQ-024 While FIFO_FULL is high in a SEND state: state, hold register and FIFO_WR_DATA are unchanged and WR_INC is 0; no byte is lost or duplicated.
REQ-025 Latency: first FIFO write is the cycle after the transfer edge if FIFO_FULL is low.
REQ-026 Throughput: minimum 2 cycles per RD byte and 3 cycles per ALU word, including the IDLE grant cycle.
REQ-027 Requests arriving in a SEND state are not acknowledged until the state returns to IDLE.
REQ-028 BUSY = (state != IDLE).
REQ-029 Bytes of one ALU word are written in order low byte then high byte, never interleaved with a read byte.

Reset
REQ-030 RST high forces, asynchronously: state IDLE, PRIO 0, hold register 0.
REQ-031 During reset: WR_INC, BUSY and FIFO_WR_DATA are 0.
REQ-032 Reset asserted mid-transfer abandons the transfer with no further WR_INC; the requester re-presents after reset.
REQ-033 The first cycle after RST deasserts is IDLE with normal arbitration.

Verification
REQ-034 Single RD: RD_REQ=1, RD_DATA=0xA5, FIFO_FULL=0 -> RD_ACK high 1 cycle; next cycle WR_INC=1 with data 0xA5; then BUSY=0.
REQ-035 Single ALU: ALU_DATA=0x1234 -> ALU_ACK 1 cycle, then two consecutive WR_INC cycles with data 0x34 then 0x12.
REQ-036 Simultaneous requests: RD_REQ=ALU_REQ=1 held after reset -> order RD, ALU, RD, ALU (round-robin); every byte written exactly once.
REQ-037 Full stall: FIFO_FULL=1 for 5 cycles in SEND_ALU_HI -> WR_INC=0 and data 0x12 stable; one write when full drops.
REQ-038 Reset mid-op: RST pulse in SEND_ALU_LO -> outputs 0 immediately; no WR_INC until a new handshake; PRIO=0.
